// File: rtl/fetch_predict_stage.sv
// Fetch stage: PC, immediate extraction, PC+4 and 2-bit-counter branch prediction.
// Optional BHT prediction is enabled by defining BRANCH_PREDICT_EN.
module fetch_predict_stage #(
  parameter int          size     = 32,
  parameter int          IDX_BITS = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            buble,
  input  logic            mispredict_i,
  input  logic [size-1:0] correct_pc_i,
  input  logic            upd_en_i,
  input  logic [size-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  output logic [size-1:0] imem_addr_o,
  input  logic [size-1:0] imem_data_i,
  output logic [size-1:0] instruction_o,
  output logic [size-1:0] IMM_o,
  output logic [size-1:0] PCplus_o,
  output logic            Predicted_MPC_o
);

  typedef enum logic [6:0] {
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_STORE  = 7'b0100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  localparam logic [size-1:0] FOUR = size'(4);

  logic [size-1:0] pc_q, pc_d;
  logic [6:0]      opcode;
  logic [31:0]     instr;
  logic [size-1:0] imm;
  logic            pred_taken;

  assign instruction_o = imem_data_i;
  assign instr         = imem_data_i[31:0];
  assign opcode        = instr[6:0];
  assign imem_addr_o   = pc_q;
  assign PCplus_o      = pc_q + FOUR;
  assign IMM_o         = imm;

  always_comb begin
    imm = {{(size-12){instr[31]}}, instr[31:20]};
    case (opcode)
      OP_BRANCH: imm = {{(size-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_JAL:    imm = {{(size-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      OP_STORE:  imm = {{(size-12){instr[31]}}, instr[31:25], instr[11:7]};
      OP_LUI,
      OP_AUIPC:  imm = {{(size-32){instr[31]}}, instr[31:12], 12'b0};
      default:   imm = {{(size-12){instr[31]}}, instr[31:20]};
    endcase
  end

`ifdef BRANCH_PREDICT_EN
  localparam int unsigned ENTRIES = 2 ** IDX_BITS;

  logic [1:0] bht_q [ENTRIES];
  logic [1:0] bht_d [ENTRIES];
  logic [1:0] upd_cnt;
  logic       unused_upd_pc;

  assign unused_upd_pc = ^{upd_pc_i[size-1:IDX_BITS+2], upd_pc_i[1:0]};
  assign upd_cnt       = bht_q[upd_pc_i[IDX_BITS+1:2]];

  // Prediction reads bht_q, so a same-cycle update to the entry is seen only next cycle.
  always_comb begin
    pred_taken = 1'b0;
    case (opcode)
      OP_BRANCH: pred_taken = bht_q[pc_q[IDX_BITS+1:2]][1];
      OP_JAL:    pred_taken = 1'b1;
      default:   pred_taken = 1'b0;
    endcase
  end

  always_comb begin
    bht_d = bht_q;
    if (upd_en_i) begin
      if (upd_taken_i) begin
        if (upd_cnt != 2'b11) bht_d[upd_pc_i[IDX_BITS+1:2]] = upd_cnt + 2'b01;
      end else begin
        if (upd_cnt != 2'b00) bht_d[upd_pc_i[IDX_BITS+1:2]] = upd_cnt - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end
`else
  logic unused_upd;

  assign unused_upd = ^{upd_en_i, upd_pc_i, upd_taken_i};
  assign pred_taken = 1'b0;
`endif

  assign Predicted_MPC_o = pred_taken;

  always_comb begin
    pc_d = pc_q + FOUR;
    if (mispredict_i)    pc_d = correct_pc_i;
    else if (buble)      pc_d = pc_q;
    else if (pred_taken) pc_d = pc_q + imm;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC[size-1:0];
    else       pc_q <= pc_d;
  end

endmodule

// File: tb/tb_fetch_predict_stage.sv
// Directed self-checking bench for fetch_predict_stage; expectations follow
// BRANCH_PREDICT_EN the same way the design does.
module tb_fetch_predict_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        buble;
  logic        mispredict_i;
  logic [31:0] correct_pc_i;
  logic        upd_en_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] instruction_o;
  logic [31:0] IMM_o;
  logic [31:0] PCplus_o;
  logic        Predicted_MPC_o;

  logic [31:0] imem [256];
  int unsigned total = 0;
  int unsigned passed = 0;

`ifdef BRANCH_PREDICT_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  fetch_predict_stage #(.size(32), .IDX_BITS(6), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .buble(buble), .mispredict_i(mispredict_i),
    .correct_pc_i(correct_pc_i), .upd_en_i(upd_en_i), .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .instruction_o(instruction_o), .IMM_o(IMM_o), .PCplus_o(PCplus_o),
    .Predicted_MPC_o(Predicted_MPC_o)
  );

  always #5 clk = ~clk;

  always_comb imem_data_i = imem[imem_addr_o[9:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] pc);
    mispredict_i = 1'b1;
    correct_pc_i = pc;
    step();
    mispredict_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++; if (imem_addr_o !== 32'h0) $display("FAIL reset_addr got=%h exp=%h", imem_addr_o, 32'h0); else passed++;
    total++; if (PCplus_o !== 32'h4) $display("FAIL reset_pcplus got=%h exp=%h", PCplus_o, 32'h4); else passed++;
    total++; if (Predicted_MPC_o !== 1'b0) $display("FAIL reset_pred got=%b exp=0", Predicted_MPC_o); else passed++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    total++; if (imem_addr_o !== 32'h0) $display("FAIL seq_addr0 got=%h exp=%h", imem_addr_o, 32'h0); else passed++;
    total++; if (instruction_o !== 32'h0000_0013) $display("FAIL seq_instr got=%h exp=%h", instruction_o, 32'h0000_0013); else passed++;
    step();
    total++; if (imem_addr_o !== 32'h4) $display("FAIL seq_addr4 got=%h exp=%h", imem_addr_o, 32'h4); else passed++;
    total++; if (PCplus_o !== 32'h8) $display("FAIL seq_pcplus8 got=%h exp=%h", PCplus_o, 32'h8); else passed++;
    step();
    total++; if (imem_addr_o !== 32'h8) $display("FAIL seq_addr8 got=%h exp=%h", imem_addr_o, 32'h8); else passed++;
    total++; if (PCplus_o !== 32'hC) $display("FAIL seq_pcplus12 got=%h exp=%h", PCplus_o, 32'hC); else passed++;
    total++; if (Predicted_MPC_o !== 1'b0) $display("FAIL seq_pred got=%b exp=0", Predicted_MPC_o); else passed++;
  endtask

  task automatic test_jal();
    goto_pc(32'h10);
    total++; if (IMM_o !== 32'h8) $display("FAIL jal_imm got=%h exp=%h", IMM_o, 32'h8); else passed++;
    total++; if (Predicted_MPC_o !== PE) $display("FAIL jal_pred got=%b exp=%b", Predicted_MPC_o, PE); else passed++;
    step();
    total++; if (imem_addr_o !== (PE ? 32'h18 : 32'h14)) $display("FAIL jal_next got=%h exp=%h", imem_addr_o, PE ? 32'h18 : 32'h14); else passed++;
  endtask

  task automatic test_branch();
    goto_pc(32'h20);
    buble = 1'b1;
    total++; if (IMM_o !== 32'h10) $display("FAIL br_imm got=%h exp=%h", IMM_o, 32'h10); else passed++;
    total++; if (Predicted_MPC_o !== 1'b0) $display("FAIL br_init_pred got=%b exp=0", Predicted_MPC_o); else passed++;
    upd_en_i = 1'b1; upd_pc_i = 32'h20; upd_taken_i = 1'b1;
    #1;
    total++; if (Predicted_MPC_o !== 1'b0) $display("FAIL br_same_cycle got=%b exp=0", Predicted_MPC_o); else passed++;
    step();
    total++; if (Predicted_MPC_o !== PE) $display("FAIL br_after_t1 got=%b exp=%b", Predicted_MPC_o, PE); else passed++;
    step();
    total++; if (Predicted_MPC_o !== PE) $display("FAIL br_after_t2 got=%b exp=%b", Predicted_MPC_o, PE); else passed++;
    step();
    step();
    total++; if (Predicted_MPC_o !== PE) $display("FAIL br_sat_t4 got=%b exp=%b", Predicted_MPC_o, PE); else passed++;
    upd_taken_i = 1'b0;
    step();
    upd_en_i = 1'b0;
    total++; if (Predicted_MPC_o !== PE) $display("FAIL br_after_nt1 got=%b exp=%b", Predicted_MPC_o, PE); else passed++;
    total++; if (imem_addr_o !== 32'h20) $display("FAIL br_stall_hold got=%h exp=%h", imem_addr_o, 32'h20); else passed++;
    buble = 1'b0;
    step();
    total++; if (imem_addr_o !== (PE ? 32'h30 : 32'h24)) $display("FAIL br_taken_next got=%h exp=%h", imem_addr_o, PE ? 32'h30 : 32'h24); else passed++;
    // Counter is now 2'b10; one more not-taken drops it to weakly not taken.
    goto_pc(32'h20);
    buble = 1'b1;
    upd_en_i = 1'b1; upd_taken_i = 1'b0;
    step();
    upd_en_i = 1'b0;
    total++; if (Predicted_MPC_o !== 1'b0) $display("FAIL br_after_nt2 got=%b exp=0", Predicted_MPC_o); else passed++;
    buble = 1'b0;
    step();
    total++; if (imem_addr_o !== 32'h24) $display("FAIL br_nt_next got=%h exp=%h", imem_addr_o, 32'h24); else passed++;
  endtask

  task automatic test_stall();
    goto_pc(32'h40);
    buble = 1'b1;
    step();
    total++; if (imem_addr_o !== 32'h40) $display("FAIL stall_c1 got=%h exp=%h", imem_addr_o, 32'h40); else passed++;
    step();
    total++; if (imem_addr_o !== 32'h40) $display("FAIL stall_c2 got=%h exp=%h", imem_addr_o, 32'h40); else passed++;
    step();
    total++; if (imem_addr_o !== 32'h40) $display("FAIL stall_c3 got=%h exp=%h", imem_addr_o, 32'h40); else passed++;
    mispredict_i = 1'b1; correct_pc_i = 32'h100;
    step();
    mispredict_i = 1'b0; buble = 1'b0;
    total++; if (imem_addr_o !== 32'h100) $display("FAIL stall_redirect got=%h exp=%h", imem_addr_o, 32'h100); else passed++;
  endtask

  task automatic test_reset_mid();
    goto_pc(32'h20);
    buble = 1'b1;
    upd_en_i = 1'b1; upd_pc_i = 32'h20; upd_taken_i = 1'b1;
    step();
    step();
    upd_en_i = 1'b0;
    total++; if (Predicted_MPC_o !== PE) $display("FAIL rst_trained got=%b exp=%b", Predicted_MPC_o, PE); else passed++;
    buble = 1'b0;
    goto_pc(32'h80);
    buble = 1'b1;
    mispredict_i = 1'b1; correct_pc_i = 32'h200;
    #2;
    reset = 1'b1;
    #1;
    total++; if (imem_addr_o !== 32'h0) $display("FAIL rst_async_addr got=%h exp=%h", imem_addr_o, 32'h0); else passed++;
    total++; if (PCplus_o !== 32'h4) $display("FAIL rst_async_pcplus got=%h exp=%h", PCplus_o, 32'h4); else passed++;
    @(posedge clk);
    #1;
    buble = 1'b0; mispredict_i = 1'b0;
    reset = 1'b0;
    total++; if (imem_addr_o !== 32'h0) $display("FAIL rst_first_fetch got=%h exp=%h", imem_addr_o, 32'h0); else passed++;
    goto_pc(32'h20);
    total++; if (Predicted_MPC_o !== 1'b0) $display("FAIL rst_bht_cleared got=%b exp=0", Predicted_MPC_o); else passed++;
  endtask

  task automatic test_imm();
    goto_pc(32'h50);
    total++; if (IMM_o !== 32'hFFFF_FFFF) $display("FAIL imm_i got=%h exp=%h", IMM_o, 32'hFFFF_FFFF); else passed++;
    step();
    total++; if (IMM_o !== 32'h1234_5000) $display("FAIL imm_lui got=%h exp=%h", IMM_o, 32'h1234_5000); else passed++;
    step();
    total++; if (IMM_o !== 32'hFFFF_FFFC) $display("FAIL imm_s got=%h exp=%h", IMM_o, 32'hFFFF_FFFC); else passed++;
    step();
    total++; if (IMM_o !== 32'h0000_1000) $display("FAIL imm_auipc got=%h exp=%h", IMM_o, 32'h0000_1000); else passed++;
    total++; if (Predicted_MPC_o !== 1'b0) $display("FAIL imm_auipc_pred got=%b exp=0", Predicted_MPC_o); else passed++;
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    total++; if (PCplus_o !== 32'h0) $display("FAIL wrap_pcplus got=%h exp=%h", PCplus_o, 32'h0); else passed++;
    step();
    total++; if (imem_addr_o !== 32'h0) $display("FAIL wrap_next got=%h exp=%h", imem_addr_o, 32'h0); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
    imem[4]  = 32'h0080_006F;
    imem[8]  = 32'h0000_0863;
    imem[20] = 32'hFFF0_0093;
    imem[21] = 32'h1234_5037;
    imem[22] = 32'hFE00_0E23;
    imem[23] = 32'h0000_1017;
    buble = 1'b0; mispredict_i = 1'b0; correct_pc_i = '0;
    upd_en_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0;
    test_reset();
    test_jal();
    test_branch();
    test_stall();
    test_reset_mid();
    test_imm();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_predict_stage.md
# fetch_predict_stage

Instruction-fetch stage that produces every input of the IF/ID pipeline register: fetched instruction, extracted sign-extended immediate, PC+4 and the branch-prediction bit. It owns the program counter and a table of 2-bit saturating counters (BHT). It selects the next PC each cycle from the EX-stage correction, the stall request or its own prediction. It sits between the instruction memory and IF/ID; the EX stage closes the loop through the correction and update ports.

## Interface
- size, 32: datapath width.
- IDX_BITS, 6: BHT index width; the table has 2^IDX_BITS entries.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears PC and BHT.
- buble  in  1  stall: hold the PC (same signal that freezes IF/ID).
- mispredict_i  in  1  EX detected a wrong next PC.
- correct_pc_i  in  size  PC to redirect to when mispredict_i=1.
- upd_en_i  in  1  EX resolved a conditional branch this cycle.
- upd_pc_i  in  size  PC of the resolved branch.
- upd_taken_i  in  1  actual branch outcome.
- imem_addr_o  out  size  current PC, sent to instruction memory.
- imem_data_i  in  size  instruction word at imem_addr_o (combinational read).
- instruction_o  out  size  equals imem_data_i.
- IMM_o  out  size  sign-extended immediate of instruction_o.
- PCplus_o  out  size  PC + 4.
- Predicted_MPC_o  out  1  1 = fetch predicted a taken control transfer.

## Operation
- Decode the opcode from instruction_o[6:0].
- Immediate by format:
  - B for 1100011.
  - J for 1101111.
  - S for 0100011.
  - U (imm[31:12], low bits 0) for 0110111 and 0010111.
  - I for all other opcodes.
  - Sign bit is always instr[31].
- BHT index: PC[IDX_BITS+1:2]. Each entry is a 2-bit counter; bit 1 = predict taken.
- Prediction:
  - Branch opcode: taken = counter[1].
  - JAL: always taken.
  - All other opcodes: not taken. JALR is resolved in EX.
- Next PC priority, highest first:
  1. mispredict_i: correct_pc_i.
  2. buble: hold PC.
  3. Predicted taken: PC + IMM_o.
  4. Otherwise: PC + 4.
- Predicted_MPC_o is 1 exactly when priority 3 would apply, independent of buble and mispredict_i.
- BHT update when upd_en_i=1: the entry at upd_pc_i[IDX_BITS+1:2] increments if upd_taken_i=1 and decrements otherwise. It saturates at 2'b00 and 2'b11.
- Updates are independent of buble and mispredict_i; they are applied even during a stall or a redirect.
- PC arithmetic is modulo 2^size; wrap from 32'hFFFF_FFFC to 0 is legal.

## Timing
- PC and BHT are the only state. Every output is combinational from the PC, the BHT and imem_data_i.
- Reset, asynchronous and immediate:
  - PC = RESET_PC, so imem_addr_o = RESET_PC and PCplus_o = RESET_PC+4.
  - All BHT entries = 2'b01 (weakly not taken).
  - IMM_o and Predicted_MPC_o follow the word at RESET_PC.
- Latency: a redirect on correct_pc_i appears on imem_addr_o one cycle later. A BHT update affects predictions from the next cycle.
- Same-cycle read and update of the same entry: the prediction uses the old value.
- Reset asserted mid-stall or mid-redirect overrides everything. The first fetch after release is RESET_PC.

## Configuration
- BRANCH_PREDICT_EN defined: behaviour as above.
- BRANCH_PREDICT_EN undefined:
  - No BHT is instantiated.
  - Predicted_MPC_o is tied to 0 and next PC is always PC+4 unless mispredict_i or buble.
  - JAL is also not predicted; EX corrects it.
  - upd_* inputs are ignored.

## Test plan
- Reset release, no stall, instruction 32'h0000_0013 (NOP): imem_addr_o sequence is 0, 4, 8. PCplus_o = 4, 8, 12. Predicted_MPC_o = 0.
- At PC 0x10, instruction 32'h0080_006F (JAL +8): Predicted_MPC_o = 1, IMM_o = 8, next imem_addr_o = 0x18. With the macro undefined, next imem_addr_o = 0x14.
- Branch BEQ +16 at PC 0x20:
  - Initially predicted not taken.
  - Apply two updates with upd_pc_i=0x20, upd_taken_i=1; from the following cycle Predicted_MPC_o = 1 and next PC = 0x30.
  - Apply two more taken updates: counter stays at 2'b11.
  - Then one not-taken update: still predicted taken.
- buble=1 for 3 cycles at PC 0x40: imem_addr_o holds 0x40. Assert mispredict_i with correct_pc_i=0x100 during the stall: next imem_addr_o = 0x100.
- Assert reset asynchronously mid-cycle at PC 0x80 after BHT training: imem_addr_o becomes RESET_PC immediately and the trained branch is again predicted not taken.
- Immediates: 32'hFFF0_0093 gives IMM_o = 32'hFFFF_FFFF (I-type). 32'h1234_5037 gives IMM_o = 32'h1234_5000 (U-type).
